exu_mdu: RTL and testbench

- Iterative RV32M multiply/divide unit: the multi-cycle successor to the single-cycle execute ALU.
- Sits beside the ALU in the execute stage and is selected when the decoded op is R-type with funct7 = 0000001.
- Uses a valid/ready handshake on both sides, accepts a pipeline flush (jump), and retires one result per operation.
- Generalised over data width and the number of bits processed per cycle.

---
 rtl/exu_pkg.sv | 35 +++
 rtl/exu_mdu_step.sv | 44 ++++
 rtl/exu_mdu.sv | 130 +++++++++++++
 tb/tb_exu_mdu.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/exu_pkg.sv
// Shared constants, state encoding and sign helpers for the iterative RV32M unit.
package exu_pkg;

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;

  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mdu_mode_t;

  // MUL is treated as signed: the low half of the product is sign-agnostic.
  function automatic logic mdu_is_signed_a(input logic [2:0] f);
    return (f == F_MUL) || (f == F_MULH) || (f == F_MULHSU) || (f == F_DIV) || (f == F_REM);
  endfunction

  function automatic logic mdu_is_signed_b(input logic [2:0] f);
    return (f == F_MUL) || (f == F_MULH) || (f == F_DIV) || (f == F_REM);
  endfunction

endpackage

// File: rtl/exu_mdu_step.sv
// Combinational UNROLL-bit iteration shared by shift-add multiply and restoring divide.
// Multiply: acc = {partial high, remaining multiplier}, op = multiplicand.
// Divide:   acc = {partial remainder, dividend/quotient}, op = divisor.
module mdu_step
  import exu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   op,
  input  mdu_mode_t         mode,
  output logic [2*XLEN-1:0] acc_next,
  output logic [XLEN-1:0]   op_next
);

  logic [2*XLEN-1:0] a_v;
  logic [2*XLEN:0]   wide;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     trial;

  // Apply UNROLL single-bit steps in sequence within one cycle.
  always_comb begin
    a_v   = acc;
    wide  = '0;
    sum   = '0;
    trial = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (mode == MODE_MUL) begin
        sum  = {1'b0, a_v[2*XLEN-1:XLEN]} + (a_v[0] ? {1'b0, op} : '0);
        wide = {sum, a_v[XLEN-1:0]};
        a_v  = wide[2*XLEN:1];
      end else begin
        wide  = {a_v, 1'b0};
        trial = wide[2*XLEN:XLEN] - {1'b0, op};
        if (!trial[XLEN]) a_v = {trial[XLEN-1:0], wide[XLEN-1:1], 1'b1};
        else              a_v = wide[2*XLEN-1:0];
      end
    end
    acc_next = a_v;
    op_next  = op;
  end

endmodule

// File: rtl/exu_mdu.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake and flush.
// state | meaning
// IDLE  | ready to accept an operation
// BUSY  | iterating UNROLL bits per cycle, counter counts down to 0
// DONE  | result valid, waiting for out_ready
module exu_mdu
  import exu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int RD_W   = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [RD_W-1:0] rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rd_out,
  output logic            busy
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  mdu_state_t        state, state_next;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, acc_next;
  logic [XLEN-1:0]   op_q, op_next;
  logic [2:0]        func_q;
  logic              neg_q;

  logic              accept, a_neg, b_neg, div_zero, ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_res, final_res;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  mdu_mode_t         mode;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign mode      = mdu_mode_t'(func_q[2]);

  mdu_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_step (
    .acc      (acc),
    .op       (op_q),
    .mode     (mode),
    .acc_next (acc_next),
    .op_next  (op_next)
  );

  // Accept-side decode: magnitudes, signs and the divide special cases.
  always_comb begin
    a_neg    = mdu_is_signed_a(func) && a[XLEN-1];
    b_neg    = mdu_is_signed_b(func) && b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = func[2] && (b == '0);
    ovf      = ((func == F_DIV) || (func == F_REM)) &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special  = div_zero || ovf;
    if (div_zero) special_res = func[1] ? a : '1;
    else          special_res = func[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // Sign fixup applied to the output of the final iteration.
  always_comb begin
    prod = neg_q ? -acc_next : acc_next;
    quo  = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem  = neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    if (!func_q[2]) final_res = (func_q == F_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else            final_res = func_q[1] ? rem : quo;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = special ? DONE : BUSY;
      BUSY:    if (cnt == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // State, datapath and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      op_q   <= '0;
      func_q <= '0;
      neg_q  <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        func_q <= func;
        rd_out <= rd_in;
        cnt    <= CW'(STEPS - 1);
        if (func[2]) begin
          acc   <= {{XLEN{1'b0}}, a_mag};
          op_q  <= b_mag;
          neg_q <= func[1] ? a_neg : (a_neg ^ b_neg);
        end else begin
          acc   <= {{XLEN{1'b0}}, b_mag};
          op_q  <= a_mag;
          neg_q <= a_neg ^ b_neg;
        end
        if (special) result <= special_res;
      end else if ((state == BUSY) && !flush) begin
        acc  <= acc_next;
        op_q <= op_next;
        if (cnt != '0) cnt <= cnt - 1'b1;
        else           result <= final_res;
      end
    end
  end

endmodule

// File: tb/tb_exu_mdu.sv
// Directed self-checking bench for exu_mdu (UNROLL=1 and UNROLL=4 builds).
module tb_exu_mdu;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [2:0]  func;
  logic [31:0] a, b;
  logic [4:0]  rd_in;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;
  logic [4:0]  rd_out;

  logic        rst4, flush4, in_valid4, out_ready4;
  logic [2:0]  func4;
  logic [31:0] a4, b4;
  logic [4:0]  rd_in4;
  logic        in_ready4, out_valid4, busy4;
  logic [31:0] result4;
  logic [4:0]  rd_out4;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  exu_mdu #(.XLEN(32), .UNROLL(1), .RD_W(5)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .a(a), .b(b), .rd_in(rd_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .rd_out(rd_out), .busy(busy)
  );

  exu_mdu #(.XLEN(32), .UNROLL(4), .RD_W(5)) dut4 (
    .clock(clock), .reset(rst4), .flush(flush4), .in_valid(in_valid4), .in_ready(in_ready4),
    .func(func4), .a(a4), .b(b4), .rd_in(rd_in4), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .rd_out(rd_out4), .busy(busy4)
  );

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one op on the UNROLL=1 unit with out_ready=1; lat counts edges including the accept edge.
  task automatic do_op(input logic [2:0] f, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [4:0] rd, output int lat);
    @(negedge clock);
    in_valid = 1'b1; func = f; a = aa; b = bb; rd_in = rd; out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h13579BDF; func = 3'd0; rd_in = 5'd0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic never_valid;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    func = 3'd0; a = '0; b = '0; rd_in = '0;
    rst4 = 1'b1; flush4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b1;
    func4 = 3'd0; a4 = '0; b4 = '0; rd_in4 = '0;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 33};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 33};
    vecs[2]  = '{3'd1, 32'h80000000,   32'h80000000, 5'd5,  32'h40000000, 33};
    vecs[3]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        5'd6,  32'hFFFFFFFD, 33};
    vecs[4]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        5'd7,  32'hFFFFFFFF, 33};
    vecs[5]  = '{3'd5, 32'd100,        32'd7,        5'd8,  32'd14,       33};
    vecs[6]  = '{3'd7, 32'd100,        32'd7,        5'd9,  32'd2,        33};
    vecs[7]  = '{3'd4, 32'd7,          32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD, 33};
    vecs[8]  = '{3'd6, 32'd7,          32'hFFFFFFFE, 5'd11, 32'd1,        33};
    vecs[9]  = '{3'd5, 32'd5,          32'd0,        5'd12, 32'hFFFFFFFF, 1};
    vecs[10] = '{3'd6, 32'd5,          32'd0,        5'd13, 32'd5,        1};
    vecs[11] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 5'd14, 32'h80000000, 1};
    vecs[12] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 5'd15, 32'd0,        1};
    vecs[13] = '{3'd4, 32'd5,          32'd0,        5'd16, 32'hFFFFFFFF, 1};
    vecs[14] = '{3'd7, 32'd5,          32'd0,        5'd17, 32'd5,        1};
    vecs[15] = '{3'd5, 32'hFFFFFFFF,   32'd1,        5'd18, 32'hFFFFFFFF, 33};

    repeat (3) @(posedge clock);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clock);
    reset = 1'b0; rst4 = 1'b0;

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp);
      check($sformatf("vec%0d_rd_out", i), {27'd0, rd_out}, {27'd0, vecs[i].rd});
      @(posedge clock); #1;
      check($sformatf("vec%0d_back_idle", i), {31'd0, in_ready}, 32'd1);
    end

    // Backpressure: hold DONE for 10 cycles.
    @(negedge clock);
    in_valid = 1'b1; func = 3'd0; a = 32'd6; b = 32'd7; rd_in = 5'd21; out_ready = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    check("bp_latency", lat, 33);
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      check($sformatf("bp_hold%0d_valid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_hold%0d_result", k), result, 32'd42);
      check($sformatf("bp_hold%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    do_op(3'd5, 32'd100, 32'd7, 5'd22, lat);
    check("bp_next_latency", lat, 33);
    check("bp_next_result", result, 32'd14);
    @(posedge clock); #1;

    // Flush during BUSY cycle 5.
    @(negedge clock);
    in_valid = 1'b1; func = 3'd0; a = 32'd9; b = 32'd9; rd_in = 5'd1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("flush_pre_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_idle", {31'd0, in_ready}, 32'd1);
    check("flush_busy", {31'd0, busy}, 32'd0);
    never_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) never_valid = 1'b0;
      @(posedge clock); #1;
    end
    check("flush_no_valid", {31'd0, never_valid}, 32'd1);

    // Flush coincident with in_valid: nothing accepted.
    @(negedge clock);
    flush = 1'b1; in_valid = 1'b1; func = 3'd5; a = 32'd5; b = 32'd0;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_accept_busy", {31'd0, busy}, 32'd0);
    check("flush_accept_valid", {31'd0, out_valid}, 32'd0);
    do_op(3'd2, 32'hFFFFFFFF, 32'd2, 5'd30, lat);
    check("mulhsu_latency", lat, 33);
    check("mulhsu_result", result, 32'hFFFFFFFF);
    @(posedge clock); #1;

    // Flush in DONE with out_ready: single handshake, back to IDLE.
    @(negedge clock);
    in_valid = 1'b1; func = 3'd5; a = 32'd5; b = 32'd0; rd_in = 5'd2; out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("flush_done_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_done_cleared", {31'd0, out_valid}, 32'd0);
    check("flush_done_in_ready", {31'd0, in_ready}, 32'd1);

    // UNROLL=4 build: multiply latency and result.
    @(negedge clock);
    in_valid4 = 1'b1; func4 = 3'd0; a4 = 32'h12345678; b4 = 32'h9ABCDEF0; rd_in4 = 5'd19;
    @(posedge clock); #1;
    in_valid4 = 1'b0; a4 = 32'h0; b4 = 32'h0;
    lat = 1;
    while (!out_valid4 && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    check("u4_latency", lat, 9);
    check("u4_result", result4, 32'h242D2080);
    check("u4_rd_out", {27'd0, rd_out4}, 32'd19);
    @(posedge clock); #1;

    // UNROLL=4 build: reset mid-operation.
    @(negedge clock);
    in_valid4 = 1'b1; func4 = 3'd1; a4 = 32'd3; b4 = 32'd5; rd_in4 = 5'd7;
    @(posedge clock); #1;
    in_valid4 = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("u4_pre_reset_busy", {31'd0, busy4}, 32'd1);
    rst4 = 1'b1;
    @(posedge clock); #1;
    check("u4_reset_valid", {31'd0, out_valid4}, 32'd0);
    check("u4_reset_busy", {31'd0, busy4}, 32'd0);
    check("u4_reset_result", result4, 32'd0);
    check("u4_reset_rd_out", {27'd0, rd_out4}, 32'd0);
    check("u4_reset_in_ready", {31'd0, in_ready4}, 32'd1);
    @(negedge clock);
    rst4 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
